// File: rtl/winner_take_all_unit.sv
// rtl/winner_take_all_unit.sv - per-class spike counters with a sequential arg-max scan
// Optional macro WTA_TIE_FLAG_EN adds the tie output.
module winner_take_all_unit #(
  parameter int NUM_CLASS = 18,
  parameter int CNT_W     = 8,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_cnt,
  input  logic             spk_valid,
  input  logic [IDX_W-1:0] spk_class,
  input  logic             get_winner,
  output logic             infer_ready,
  output logic [IDX_W-1:0] winner,
  output logic [CNT_W-1:0] winner_cnt,
`ifdef WTA_TIE_FLAG_EN
  output logic             tie,
`endif
  output logic             busy
);

  localparam logic [IDX_W:0]   NUM_CLASS_W = (IDX_W+1)'(NUM_CLASS);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CLASS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q [NUM_CLASS];
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] best_idx_q;
  logic [CNT_W-1:0] best_cnt_q;
  logic [IDX_W-1:0] winner_q;
  logic [CNT_W-1:0] winner_cnt_q;
  logic             infer_ready_q;

  logic             class_ok_d;
  logic [CNT_W-1:0] scan_cnt_d;
  logic             take_d;

  assign class_ok_d = ({1'b0, spk_class} < NUM_CLASS_W);
  assign scan_cnt_d = cnt_q[idx_q];
  // Strictly greater keeps the earliest (lowest) index on ties.
  assign take_d     = (scan_cnt_d > best_cnt_q);

`ifdef WTA_TIE_FLAG_EN
  logic tie_seen_q;
  logic tie_q;
  assign tie = tie_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      best_idx_q    <= '0;
      best_cnt_q    <= '0;
      winner_q      <= '0;
      winner_cnt_q  <= '0;
      infer_ready_q <= 1'b0;
      for (int i = 0; i < NUM_CLASS; i++) cnt_q[i] <= '0;
`ifdef WTA_TIE_FLAG_EN
      tie_seen_q    <= 1'b0;
      tie_q         <= 1'b0;
`endif
    end else begin
      infer_ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (spk_valid && class_ok_d && (cnt_q[spk_class] != CNT_MAX))
            cnt_q[spk_class] <= cnt_q[spk_class] + CNT_W'(1);
          if (get_winner) begin
            state_q    <= SCAN;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_cnt_q <= '0;
`ifdef WTA_TIE_FLAG_EN
            tie_seen_q <= 1'b0;
            tie_q      <= 1'b0;
`endif
          end
        end
        SCAN: begin
          if (take_d) begin
            best_cnt_q <= scan_cnt_d;
            best_idx_q <= idx_q;
`ifdef WTA_TIE_FLAG_EN
            tie_seen_q <= 1'b0;
          end else if ((scan_cnt_d == best_cnt_q) && (best_cnt_q != '0)) begin
            tie_seen_q <= 1'b1;
`endif
          end
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) state_q <= DONE;
        end
        DONE: begin
          winner_q      <= best_idx_q;
          winner_cnt_q  <= best_cnt_q;
          infer_ready_q <= 1'b1;
          state_q       <= IDLE;
`ifdef WTA_TIE_FLAG_EN
          tie_q         <= tie_seen_q;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign infer_ready = infer_ready_q;
  assign winner      = winner_q;
  assign winner_cnt  = winner_cnt_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/winner_take_all_unit.md
# winner_take_all_unit

Downstream of the inter-layer state machine: counts output-layer spikes per class during one sample's inference and, on `get_winner`, finds the class with the most spikes by a sequential scan. It returns `infer_ready` with the winning class index. Counters are cleared by the sample request so each sample starts from zero.

## Interface
- `NUM_CLASS`, 18: number of output classes / counters.
- `CNT_W`, 8: spike counter width; counters saturate.
- `IDX_W`, 5: class index width; must satisfy 2^IDX_W >= NUM_CLASS.

- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset is synchronous and active-low.
- `clr_cnt`, in, 1: zero all counters and the result. Driven by `rqt_new_sample`.
- `spk_valid`, in, 1: one output-layer spike this cycle.
- `spk_class`, in, IDX_W: class of that spike.
- `get_winner`, in, 1: start the scan; single-cycle pulse.
- `infer_ready`, out, 1: one-cycle pulse; result valid.
- `winner`, out, IDX_W: winning class index; held until the next clear or scan.
- `winner_cnt`, out, CNT_W: spike count of the winner.
- `busy`, out, 1: high in SCAN and DONE.

## Operation
- On reset (`rst_n`=0 at a clock edge):
  - all counters 0, state IDLE;
  - `infer_ready`=0, `winner`=0, `winner_cnt`=0, `busy`=0.
- Counting, in IDLE only:
  - `spk_valid`=1 with `spk_class` < NUM_CLASS increments `cnt[spk_class]` by 1, saturating at 2^CNT_W-1.
  - `spk_class` >= NUM_CLASS is ignored.
  - Spikes in SCAN or DONE are dropped; counters are frozen during the scan.
- States:
  - IDLE --`get_winner`--> SCAN: index register = 0, best_cnt = 0, best_idx = 0.
  - SCAN: each cycle compares `cnt[idx]` against best_cnt. Strictly greater replaces the best, so ties go to the lowest index. `idx` increments. After `idx` = NUM_CLASS-1 is compared, go to DONE.
  - DONE: `winner` <= best_idx, `winner_cnt` <= best_cnt, `infer_ready`=1 for this cycle, then IDLE.
- All counters zero: the winner is 0 and `winner_cnt` is 0.
- `clr_cnt`:
  - In any state, it zeroes counters, `winner` and `winner_cnt`, and returns to IDLE.
  - In SCAN it aborts the scan; no `infer_ready` is produced.
  - It has priority over `spk_valid` and `get_winner` in the same cycle: the spike is discarded and no scan starts.
- `get_winner` in SCAN or DONE is ignored.
- `get_winner` and `spk_valid` together in IDLE: the spike is counted and the scan starts the next cycle with the updated counter.

## Timing
- `get_winner` sampled at edge T:
  - SCAN occupies edges T+1 .. T+NUM_CLASS;
  - DONE at T+NUM_CLASS+1: `infer_ready` is high in the cycle after that edge.
  - Latency is NUM_CLASS+1 cycles (19 at default).
- `busy` goes high the cycle after `get_winner` and low the cycle after DONE.
- `infer_ready` is registered, with no combinational path from inputs. `winner` and `winner_cnt` are stable in the same cycle as `infer_ready` and afterwards.
- A counter increment is visible one cycle after `spk_valid`.
- Synchronous reset mid-scan behaves like `clr_cnt` and also clears the outputs.

## Configuration
- `WTA_TIE_FLAG_EN` defined:
  - adds output `tie`, 1 bit, reset value 0;
  - set at DONE if another class equals best_cnt and best_cnt > 0;
  - cleared by `clr_cnt` or a new scan.
- Not defined: no `tie` port and no tie logic; winner selection is unchanged.

## Test plan
- Reset, then 3 spikes to class 5 and 1 to class 2, then `get_winner` -> `infer_ready` 19 cycles later, `winner`=5, `winner_cnt`=3.
- Tie: 4 spikes each to classes 7 and 3 -> `winner`=3, `winner_cnt`=4; `tie`=1 with `WTA_TIE_FLAG_EN`.
- Saturation: 300 spikes to class 17 with CNT_W=8 -> `winner`=17, `winner_cnt`=255.
- No spikes, then `get_winner` -> `winner`=0, `winner_cnt`=0, `tie`=0.
- `clr_cnt` asserted 5 cycles into a scan -> no `infer_ready`, outputs 0, `busy`=0 the next cycle; a subsequent spike to class 9 and `get_winner` -> `winner`=9.
- Spikes during SCAN, `spk_class`=20, and a second `get_winner` mid-scan -> all ignored; one `infer_ready` with the pre-scan result.
